multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPCODE_W, default 4, SHALL set the opcode width.
REQ-002 Parameter ALUOP_W, default 2, SHALL set the ALUOp width.
REQ-003 Parameter CNT_W, default 16, SHALL set the InstrCount width.
REQ-004 Parameters OP_R=6, OP_I=1, OP_LW=2, OP_SW=3, OP_BEQ=4 SHALL set the opcode encodings; each is OPCODE_W wide.
REQ-005 Clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 Run  in  1  SHALL, when 1 in IDLE, start instruction execution.
REQ-008 OPCODE  in  OPCODE_W  opcode field from the instruction register, sampled in DECODE.
REQ-009 MemReady  in  1  memory-access completion handshake.
REQ-010 Zero  in  1  ALU zero flag, sampled in BRANCH.
REQ-011 RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls.
REQ-012 ALUOp  out  ALUOP_W  ALU operation class: 00 add, 01 subtract, 10 function field.
REQ-013 PCWrite, IRWrite  out  1 each  PC and IR load enables.
REQ-014 Illegal  out  1  SHALL indicate that an unknown opcode was trapped.
REQ-015 InstrCount  out  CNT_W  retired-instruction counter.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, RWB, ADDR, MEMRD, LWB, MEMWR, BRANCH and TRAP.
REQ-017 Every output SHALL be 0 in any state except where the following requirements set it; no output SHALL ever be X.
REQ-018 IDLE: the FSM SHALL go to FETCH when Run=1 and stay in IDLE otherwise.
REQ-019 FETCH: MemRead=1 SHALL be asserted; when MemReady=1, IRWrite=1 and PCWrite=1 SHALL be asserted for that cycle, with a transition to DECODE; otherwise the FSM SHALL stay in FETCH.
REQ-020 DECODE: the FSM SHALL take one cycle and then go to EXEC for OP_R/OP_I, ADDR for OP_LW/OP_SW, BRANCH for OP_BEQ, and TRAP for any other code.
REQ-021 EXEC: ALUSrc SHALL be 0 and ALUOp 10 for OP_R; ALUSrc SHALL be 1 and ALUOp 00 for OP_I; the next state SHALL be RWB.
REQ-022 RWB: RegWrite=1 and RegDst=1 (OP_R) or 0 (OP_I) SHALL be asserted, with the same ALUSrc and ALUOp values as EXEC; the next state SHALL be FETCH.
REQ-023 ADDR: ALUSrc=1 and ALUOp=00 SHALL be asserted; the next state SHALL be MEMRD for OP_LW and MEMWR for OP_SW.
REQ-024 MEMRD: MemRead=1, ALUSrc=1 and ALUOp=00 SHALL be held until MemReady=1, then the FSM SHALL go to LWB.
REQ-025 LWB: RegWrite=1, MemToReg=1 and RegDst=0 SHALL be asserted; the next state SHALL be FETCH.
REQ-026 MEMWR: MemWrite=1, ALUSrc=1 and ALUOp=00 SHALL be held until MemReady=1, then the FSM SHALL go to FETCH; RegWrite SHALL stay 0.
REQ-027 BRANCH: Branch=1, ALUSrc=0 and ALUOp=01 SHALL be asserted, and PCWrite SHALL equal Zero; the next state SHALL be FETCH.
REQ-028 TRAP: Illegal=1 SHALL be asserted; TRAP SHALL be sticky and exit only through reset; Run SHALL be ignored.
REQ-029 The opcode SHALL be latched into an internal register in DECODE; all later states SHALL use the latched value and ignore OPCODE changes.
REQ-030 Latency SHALL be, with MemReady tied to 1: R/I 4 cycles, LW 5, SW 4, BEQ 3 (FETCH to FETCH).
REQ-031 InstrCount SHALL increment by 1 on every transition into FETCH from RWB, LWB, MEMWR or BRANCH, and SHALL wrap from all-ones to 0.
REQ-032 Entry into TRAP SHALL NOT increment InstrCount.
REQ-033 MemReady SHALL be ignored in every state except FETCH, MEMRD and MEMWR.
REQ-034 Run=0 outside IDLE SHALL have no effect; the FSM SHALL never return to IDLE except through reset.

Reset
REQ-035 Reset=0 SHALL force the FSM to IDLE, InstrCount to 0, the latched opcode to 0 and all outputs to 0, immediately and without waiting for Clock.
REQ-036 A reset asserted mid-instruction, including during a pending MemReady wait, SHALL abort the instruction with no further write enables.
REQ-037 After reset release the FSM SHALL stay in IDLE until Run=1 is sampled on a rising Clock edge.

Verification
REQ-038 Run=1, OPCODE=0110, MemReady=1 -> states FETCH, DECODE, EXEC, RWB; RegWrite=1 and RegDst=1 in RWB; InstrCount=1 after 4 cycles.
REQ-039 OPCODE=0010 with MemReady low for 3 cycles in MEMRD -> MemRead held 4 cycles; LWB asserts MemToReg=1 and RegWrite=1; LW takes 8 cycles in total.
REQ-040 OPCODE=0100 with Zero=1 -> PCWrite=1 in BRANCH; repeat with Zero=0 -> PCWrite=0; InstrCount increments in both cases.
REQ-041 OPCODE=1111 -> TRAP, Illegal=1, InstrCount unchanged; it stays there for 10 cycles of Run=1 and exits only on Reset=0.
REQ-042 CNT_W=4 with 16 retired SW instructions -> InstrCount wraps to 0; a Reset=0 pulse during MEMWR -> MemWrite=0 immediately and InstrCount=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle datapath: steps each instruction through fetch, decode,
// execute, memory and writeback, and traps unknown opcodes until reset.
module multicycle_control #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16,
  parameter logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(6),
  parameter logic [OPCODE_W-1:0] OP_I   = OPCODE_W'(1),
  parameter logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(2),
  parameter logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(3),
  parameter logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(4)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Run,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                MemReady,
  input  logic                Zero,
  output logic                RegDst,
  output logic                ALUSrc,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                Branch,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                Illegal,
  output logic [CNT_W-1:0]    InstrCount
);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(2);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, RWB, ADDR, MEMRD, LWB, MEMWR, BRANCH, TRAP
  } state_t;

  state_t               state, nxt;
  logic [OPCODE_W-1:0]  op_q, op_eff;
  logic                 retire;
  logic                 n_regdst, n_alusrc, n_memtoreg, n_regwrite;
  logic                 n_memread, n_memwrite, n_branch, n_illegal;
  logic [ALUOP_W-1:0]   n_aluop;

  // The opcode is live on the bus only during DECODE; afterwards the latched copy rules.
  always_comb begin
    op_eff = (state == DECODE) ? OPCODE : op_q;
    nxt    = state;
    retire = 1'b0;
    case (state)
      IDLE:   if (Run) nxt = FETCH;
      FETCH:  if (MemReady) nxt = DECODE;
      DECODE: begin
        if (op_eff == OP_R || op_eff == OP_I)        nxt = EXEC;
        else if (op_eff == OP_LW || op_eff == OP_SW) nxt = ADDR;
        else if (op_eff == OP_BEQ)                   nxt = BRANCH;
        else                                         nxt = TRAP;
      end
      EXEC:   nxt = RWB;
      RWB:    begin nxt = FETCH; retire = 1'b1; end
      ADDR:   nxt = (op_eff == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (MemReady) nxt = LWB;
      LWB:    begin nxt = FETCH; retire = 1'b1; end
      MEMWR:  if (MemReady) begin nxt = FETCH; retire = 1'b1; end
      BRANCH: begin nxt = FETCH; retire = 1'b1; end
      TRAP:   nxt = TRAP;
      default: nxt = IDLE;
    endcase
  end

  // State-decoded controls are computed for the state being entered so they register cleanly.
  always_comb begin
    n_regdst   = 1'b0;
    n_alusrc   = 1'b0;
    n_memtoreg = 1'b0;
    n_regwrite = 1'b0;
    n_memread  = 1'b0;
    n_memwrite = 1'b0;
    n_branch   = 1'b0;
    n_illegal  = 1'b0;
    n_aluop    = ALU_ADD;
    case (nxt)
      FETCH:  n_memread = 1'b1;
      EXEC:   begin
        n_alusrc = (op_eff != OP_R);
        n_aluop  = (op_eff == OP_R) ? ALU_FUNC : ALU_ADD;
      end
      RWB:    begin
        n_regwrite = 1'b1;
        n_regdst   = (op_eff == OP_R);
        n_alusrc   = (op_eff != OP_R);
        n_aluop    = (op_eff == OP_R) ? ALU_FUNC : ALU_ADD;
      end
      ADDR:   n_alusrc = 1'b1;
      MEMRD:  begin n_memread = 1'b1; n_alusrc = 1'b1; end
      LWB:    begin n_regwrite = 1'b1; n_memtoreg = 1'b1; end
      MEMWR:  begin n_memwrite = 1'b1; n_alusrc = 1'b1; end
      BRANCH: begin n_branch = 1'b1; n_aluop = ALU_SUB; end
      TRAP:   n_illegal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      op_q       <= '0;
      InstrCount <= '0;
      RegDst     <= 1'b0;
      ALUSrc     <= 1'b0;
      MemToReg   <= 1'b0;
      RegWrite   <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Branch     <= 1'b0;
      Illegal    <= 1'b0;
      ALUOp      <= ALU_ADD;
    end else begin
      state <= nxt;
      if (state == DECODE) op_q <= OPCODE;
      if (retire) InstrCount <= InstrCount + CNT_W'(1);
      RegDst   <= n_regdst;
      ALUSrc   <= n_alusrc;
      MemToReg <= n_memtoreg;
      RegWrite <= n_regwrite;
      MemRead  <= n_memread;
      MemWrite <= n_memwrite;
      Branch   <= n_branch;
      Illegal  <= n_illegal;
      ALUOp    <= n_aluop;
    end
  end

  // Load enables follow the handshake / zero flag within the same cycle.
  assign IRWrite = (state == FETCH) && MemReady;
  assign PCWrite = ((state == FETCH) && MemReady) || ((state == BRANCH) && Zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each instruction is expanded into a per-cycle list of expected
// control vectors, then replayed against the controller.
module tb_multicycle_control;

  localparam int OW = 4;
  localparam int AW = 2;
  localparam int CW = 4;

  logic          Clock = 1'b0;
  logic          Reset, Run, MemReady, Zero;
  logic [OW-1:0] OPCODE;
  logic          RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch;
  logic [AW-1:0] ALUOp;
  logic          PCWrite, IRWrite, Illegal;
  logic [CW-1:0] InstrCount;

  multicycle_control #(.OPCODE_W(OW), .ALUOP_W(AW), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .OPCODE(OPCODE), .MemReady(MemReady),
    .Zero(Zero), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .ALUOp(ALUOp), .PCWrite(PCWrite), .IRWrite(IRWrite), .Illegal(Illegal),
    .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic          run;
    logic [OW-1:0] op;
    logic          mr;
    logic          z;
    logic [11:0]   out;
    logic [CW-1:0] cnt;
  } cyc_t;

  cyc_t          q[$];
  int            nvec = 0;
  int            nerr = 0;
  logic [CW-1:0] mcnt;
  logic [OW-1:0] legal [5];

  wire [11:0] obs = {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch,
                     ALUOp, PCWrite, IRWrite, Illegal};

  function automatic logic [11:0] o(input logic rd, as, m2r, rw, mrd, mwr, br,
                                    input logic [1:0] aop, input logic pcw, irw, ill);
    return {rd, as, m2r, rw, mrd, mwr, br, aop, pcw, irw, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // -1 means "don't care": the input is randomized to show it is ignored.
  task automatic push(input int run, input int op, input int mr, input int z,
                      input logic [11:0] out);
    cyc_t c;
    c.run = (run < 0) ? 1'($urandom) : 1'(run);
    c.op  = (op  < 0) ? OW'($urandom) : OW'(op);
    c.mr  = (mr  < 0) ? 1'($urandom) : 1'(mr);
    c.z   = (z   < 0) ? 1'($urandom) : 1'(z);
    c.out = out;
    c.cnt = mcnt;
    q.push_back(c);
  endtask

  task automatic idle_start();
    push(0, -1, -1, -1, '0);
    push(0, -1, -1, -1, '0);
    push(1, -1, -1, -1, '0);
  endtask

  task automatic fetch_decode(input logic [OW-1:0] op, input int fw);
    for (int i = 0; i < fw; i++) push(-1, -1, 0, -1, o(0,0,0,0,1,0,0,2'd0,0,0,0));
    push(-1, -1, 1, -1, o(0,0,0,0,1,0,0,2'd0,1,1,0));
    push(-1, int'(op), -1, -1, '0);
  endtask

  task automatic instr(input logic [OW-1:0] op, input int fw, input int mw, input logic z);
    fetch_decode(op, fw);
    case (op)
      4'd6: begin
        push(-1, -1, -1, -1, o(0,0,0,0,0,0,0,2'd2,0,0,0));
        push(-1, -1, -1, -1, o(1,0,0,1,0,0,0,2'd2,0,0,0));
        mcnt++;
      end
      4'd1: begin
        push(-1, -1, -1, -1, o(0,1,0,0,0,0,0,2'd0,0,0,0));
        push(-1, -1, -1, -1, o(0,1,0,1,0,0,0,2'd0,0,0,0));
        mcnt++;
      end
      4'd2: begin
        push(-1, -1, -1, -1, o(0,1,0,0,0,0,0,2'd0,0,0,0));
        for (int i = 0; i < mw; i++) push(-1, -1, 0, -1, o(0,1,0,0,1,0,0,2'd0,0,0,0));
        push(-1, -1, 1, -1, o(0,1,0,0,1,0,0,2'd0,0,0,0));
        push(-1, -1, -1, -1, o(0,0,1,1,0,0,0,2'd0,0,0,0));
        mcnt++;
      end
      4'd3: begin
        push(-1, -1, -1, -1, o(0,1,0,0,0,0,0,2'd0,0,0,0));
        for (int i = 0; i < mw; i++) push(-1, -1, 0, -1, o(0,1,0,0,0,1,0,2'd0,0,0,0));
        push(-1, -1, 1, -1, o(0,1,0,0,0,1,0,2'd0,0,0,0));
        mcnt++;
      end
      4'd4: begin
        push(-1, -1, -1, int'(z), o(0,0,0,0,0,0,1,2'd1,z,0,0));
        mcnt++;
      end
      default: begin
        for (int i = 0; i < 12; i++) push(1, -1, -1, -1, o(0,0,0,0,0,0,0,2'd0,0,0,1));
      end
    endcase
  endtask

  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge Clock);
      Run = c.run; OPCODE = c.op; MemReady = c.mr; Zero = c.z;
      #1;
      chk("ctrl", 32'(obs), 32'(c.out));
      chk("count", 32'(InstrCount), 32'(c.cnt));
    end
  endtask

  task automatic reset_now(input string tag);
    Reset = 1'b0;
    #1;
    chk({tag, "_ctrl"}, 32'(obs), 32'd0);
    chk({tag, "_count"}, 32'(InstrCount), 32'd0);
    Run = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    mcnt = '0;
  endtask

  initial begin
    legal[0] = 4'd6; legal[1] = 4'd1; legal[2] = 4'd2; legal[3] = 4'd3; legal[4] = 4'd4;
    Run = 1'b0; OPCODE = '0; MemReady = 1'b0; Zero = 1'b0;
    mcnt = '0;
    reset_now("por");

    idle_start();
    instr(4'd6, 0, 0, 1'b0);
    instr(4'd2, 0, 3, 1'b0);
    instr(4'd4, 0, 0, 1'b1);
    instr(4'd4, 0, 0, 1'b0);
    for (int i = 0; i < 16; i++) instr(4'd3, 0, 0, 1'b0);
    run_queue();

    for (int i = 0; i < 40; i++)
      instr(legal[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(0, 2),
            1'($urandom));
    run_queue();

    // Abort an SW while it waits on MemReady in MEMWR.
    fetch_decode(4'd3, 1);
    push(-1, -1, -1, -1, o(0,1,0,0,0,0,0,2'd0,0,0,0));
    push(-1, -1, 0, -1, o(0,1,0,0,0,1,0,2'd0,0,0,0));
    run_queue();
    reset_now("abort");

    idle_start();
    instr(4'd4, 0, 0, 1'b1);
    instr(4'd15, 0, 0, 1'b0);
    run_queue();
    reset_now("trap");

    idle_start();
    instr(4'd1, 1, 0, 1'b0);
    instr(4'd5, 0, 0, 1'b0);
    run_queue();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
